// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states
// and the divide iteration count.
package hilo_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MADD  = 3'b100,
      OP_MSUB  = 3'b101,
      OP_MTHI  = 3'b110,
      OP_MTLO  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_DIV_RUN = 2'd1,
      S_DIV_FIX = 2'd2
   } state_e;

   localparam int DIV_STEPS = 32;

   // Two's-complement magnitude; 0x80000000 maps to itself, which reads
   // correctly as an unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Issue/result bundle between the pipeline and the HI/LO unit.
interface hilo_muldiv_unit_if;

   logic        Start;
   logic [2:0]  Op;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic        Done;
   logic        DivByZero;
   logic [31:0] Hi;
   logic [31:0] Lo;

   modport master (
      output Start, Op, A, B,
      input  Busy, Done, DivByZero, Hi, Lo
   );

   modport slave (
      input  Start, Op, A, B,
      output Busy, Done, DivByZero, Hi, Lo
   );

endinterface

// File: rtl/hilo_muldiv_unit_div_step.sv
// One combinational restoring-division step on a packed {rem,quo} register.
module div_step (
   input  logic [63:0] rq_i,
   input  logic [31:0] divisor_i,
   output logic [63:0] rq_o
);

   logic [32:0] partial;
   logic [32:0] trial;

   // The shift can push one bit above the 32-bit remainder, so trial in 33 bits.
   assign partial = rq_i[63:31];
   assign trial   = partial - {1'b0, divisor_i};

   always_comb begin
      if (!trial[32]) begin
         rq_o = {trial[31:0], rq_i[30:0], 1'b1};
      end else begin
         rq_o = {partial[31:0], rq_i[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Owner of the architectural HI/LO registers: single-cycle multiply/accumulate
// and moves, 32-step iterative restoring divide that holds Busy while running.
module hilo_muldiv_unit
   import hilo_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Rst,
   hilo_muldiv_unit_if.slave    bus
);

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] rq_q, rq_d;
   logic [31:0] dvs_q, dvs_d;
   logic        qneg_q, qneg_d;
   logic        rneg_q, rneg_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        dbz_q, dbz_d;

   logic signed [63:0] a_sx, b_sx, prod_s;
   logic        [63:0] prod_u;
   logic        [63:0] acc;
   logic        [63:0] rq_step;
   logic        [31:0] quo, rem;

   assign a_sx   = {{32{bus.A[31]}}, bus.A};
   assign b_sx   = {{32{bus.B[31]}}, bus.B};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
   assign acc    = {hi_q, lo_q};
   assign quo    = rq_q[31:0];
   assign rem    = rq_q[63:32];

   div_step u_div_step (
      .rq_i      (rq_q),
      .divisor_i (dvs_q),
      .rq_o      (rq_step)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rq_d    = rq_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbz_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               case (op_e'(bus.Op))
                  OP_MULT:  begin {hi_d, lo_d} = prod_s;       done_d = 1'b1; end
                  OP_MULTU: begin {hi_d, lo_d} = prod_u;       done_d = 1'b1; end
                  OP_MADD:  begin {hi_d, lo_d} = acc + prod_s; done_d = 1'b1; end
                  OP_MSUB:  begin {hi_d, lo_d} = acc - prod_s; done_d = 1'b1; end
                  OP_MTHI:  begin hi_d = bus.A;                done_d = 1'b1; end
                  OP_MTLO:  begin lo_d = bus.A;                done_d = 1'b1; end
                  default: begin
                     if (bus.B == 32'd0) begin
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                     end else begin
                        state_d = S_DIV_RUN;
                        cnt_d   = 5'd0;
                        if (op_e'(bus.Op) == OP_DIV) begin
                           rq_d   = {32'd0, abs32(bus.A)};
                           dvs_d  = abs32(bus.B);
                           qneg_d = bus.A[31] ^ bus.B[31];
                           rneg_d = bus.A[31];
                        end else begin
                           rq_d   = {32'd0, bus.A};
                           dvs_d  = bus.B;
                           qneg_d = 1'b0;
                           rneg_d = 1'b0;
                        end
                     end
                  end
               endcase
            end
         end

         S_DIV_RUN: begin
            rq_d  = rq_step;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_STEPS - 1)) begin
               state_d = S_DIV_FIX;
               cnt_d   = 5'd0;
            end
         end

         S_DIV_FIX: begin
            lo_d    = qneg_q ? (32'd0 - quo) : quo;
            hi_d    = rneg_q ? (32'd0 - rem) : rem;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         rq_q    <= 64'd0;
         dvs_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rq_q    <= rq_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
      end
   end

   assign bus.Busy      = busy_q;
   assign bus.Done      = done_q;
   assign bus.DivByZero = dbz_q;
   assign bus.Hi        = hi_q;
   assign bus.Lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed cases plus random ops
// against a plain-arithmetic HI/LO reference model.
module tb_hilo_muldiv_unit;

   logic Clk;
   logic Rst;

   hilo_muldiv_unit_if bus ();

   hilo_muldiv_unit dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] mhi = 32'd0;
   logic [31:0] mlo = 32'd0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Architectural result computed with 64-bit integer arithmetic.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic dbz);
      longint          sa, sb, p, q, r;
      longint unsigned ua, ub, pu, qu, ru;
      logic [63:0]     hl;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      hl  = {mhi, mlo};
      dbz = 1'b0;
      case (op)
         3'd0: begin p = sa * sb; {mhi, mlo} = p; end
         3'd1: begin pu = ua * ub; {mhi, mlo} = pu; end
         3'd2: begin
            if (b == 32'd0) dbz = 1'b1;
            else begin
               q = sa / sb; r = sa % sb;
               mlo = q[31:0]; mhi = r[31:0];
            end
         end
         3'd3: begin
            if (b == 32'd0) dbz = 1'b1;
            else begin
               qu = ua / ub; ru = ua % ub;
               mlo = qu[31:0]; mhi = ru[31:0];
            end
         end
         3'd4: begin p = longint'(hl) + sa * sb; {mhi, mlo} = p; end
         3'd5: begin p = longint'(hl) - sa * sb; {mhi, mlo} = p; end
         3'd6: mhi = a;
         default: mlo = a;
      endcase
   endtask

   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit inject);
      logic        exp_dbz;
      bit          is_div;
      int          cyc;
      logic [31:0] hold_hi, hold_lo;
      hold_hi = mhi;
      hold_lo = mlo;
      is_div  = (op == 3'd2 || op == 3'd3) && (b != 32'd0);
      model(op, a, b, exp_dbz);

      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
      @(negedge Clk);
      bus.Start = 1'b0;

      if (is_div) begin
         cyc = 0;
         while (bus.Busy === 1'b1 && cyc < 100) begin
            cyc++;
            check("div_hold_hi", 64'(bus.Hi), 64'(hold_hi));
            check("div_hold_lo", 64'(bus.Lo), 64'(hold_lo));
            check("div_no_done", 64'(bus.Done), 64'd0);
            bus.Op = 3'($urandom);
            bus.A  = $urandom;
            bus.B  = $urandom;
            if (inject && cyc == 10) begin
               bus.Start = 1'b1;
               bus.Op    = 3'd7;
            end else begin
               bus.Start = 1'b0;
            end
            @(negedge Clk);
         end
         bus.Start = 1'b0;
         check("div_busy_cycles", 64'(cyc), 64'd33);
      end else begin
         check("busy_low", 64'(bus.Busy), 64'd0);
      end

      check("done_pulse", 64'(bus.Done), 64'd1);
      check("divbyzero", 64'(bus.DivByZero), 64'(exp_dbz));
      check("hi", 64'(bus.Hi), 64'(mhi));
      check("lo", 64'(bus.Lo), 64'(mlo));
      @(negedge Clk);
      check("done_drop", 64'(bus.Done), 64'd0);
      check("dbz_drop", 64'(bus.DivByZero), 64'd0);
      check("busy_idle", 64'(bus.Busy), 64'd0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      bus.Start = 1'b0; bus.Op = 3'd0; bus.A = 32'd0; bus.B = 32'd0;
      Rst = 1'b1;
      #3;
      check("rst_hi", 64'(bus.Hi), 64'd0);
      check("rst_lo", 64'(bus.Lo), 64'd0);
      check("rst_busy", 64'(bus.Busy), 64'd0);
      check("rst_done", 64'(bus.Done), 64'd0);
      check("rst_dbz", 64'(bus.DivByZero), 64'd0);
      @(negedge Clk);
      Rst = 1'b0;

      // Directed cases
      do_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
      check("mult_hi_const", 64'(bus.Hi), 64'hFFFFFFFF);
      check("mult_lo_const", 64'(bus.Lo), 64'hFFFFFFFA);
      do_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
      check("multu_hi_const", 64'(bus.Hi), 64'h2);
      do_op(3'd6, 32'h1, 32'd0, 1'b0);
      do_op(3'd7, 32'hFFFFFFFF, 32'd0, 1'b0);
      do_op(3'd4, 32'd1, 32'd1, 1'b0);
      check("madd_hi_const", 64'(bus.Hi), 64'h2);
      check("madd_lo_const", 64'(bus.Lo), 64'h0);
      do_op(3'd5, 32'd1, 32'd1, 1'b0);
      check("msub_hi_const", 64'(bus.Hi), 64'h1);
      check("msub_lo_const", 64'(bus.Lo), 64'hFFFFFFFF);
      do_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
      check("div_lo_const", 64'(bus.Lo), 64'hFFFFFFFD);
      check("div_hi_const", 64'(bus.Hi), 64'hFFFFFFFF);
      do_op(3'd6, 32'h5, 32'd0, 1'b0);
      do_op(3'd7, 32'h6, 32'd0, 1'b0);
      do_op(3'd3, 32'h12345678, 32'd0, 1'b0);
      check("dbz_hi_const", 64'(bus.Hi), 64'h5);
      check("dbz_lo_const", 64'(bus.Lo), 64'h6);
      do_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
      check("divmin_lo_const", 64'(bus.Lo), 64'h80000000);
      check("divmin_hi_const", 64'(bus.Hi), 64'h0);

      // Reset in the middle of a divide
      @(negedge Clk);
      bus.Start = 1'b1; bus.Op = 3'd3; bus.A = 32'hDEADBEEF; bus.B = 32'd7;
      @(negedge Clk);
      bus.Start = 1'b0;
      repeat (10) @(negedge Clk);
      check("mid_busy", 64'(bus.Busy), 64'd1);
      #2 Rst = 1'b1;
      #1;
      check("abort_hi", 64'(bus.Hi), 64'd0);
      check("abort_lo", 64'(bus.Lo), 64'd0);
      check("abort_busy", 64'(bus.Busy), 64'd0);
      mhi = 32'd0;
      mlo = 32'd0;
      @(negedge Clk);
      Rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge Clk);
         check("abort_no_done", 64'(bus.Done), 64'd0);
         check("abort_no_busy", 64'(bus.Busy), 64'd0);
      end

      // Random operations
      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 9));
            2:       rb = 32'hFFFFFFFF;
            default: rb = $urandom;
         endcase
         do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, limit 2000000");
      $fatal(1);
   end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Multi-cycle HI/LO unit for the MIPS datapath: owns the architectural HI and LO registers and executes every instruction that writes them (mult, multu, div, divu, madd, msub, mthi, mtlo). The EX-stage ALU's single-cycle 64-bit multiply path is the producer side; this block is the consumer and owner of that result. Its Hi/Lo outputs are the read port for mfhi/mflo. Division is iterative, and Busy stalls the pipeline while it runs.

## Interface
- No parameters; width fixed at 32 bits.
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Start  in  1  issue strobe; sampled only when Busy=0
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB, 110 MTHI, 111 MTLO
- A  in  32  rs operand (dividend / multiplicand / move source)
- B  in  32  rt operand (divisor / multiplier)
- Busy  out  1  high while a divide is in flight
- Done  out  1  one-cycle pulse: HI/LO were written at the preceding edge
- DivByZero  out  1  one-cycle pulse, coincident with Done, for a DIV/DIVU with B=0
- Hi  out  32  HI register
- Lo  out  32  LO register

## Operation
- States: IDLE, DIV_RUN, DIV_FIX.
- IDLE + Start + MULT/MULTU:
  - {Hi,Lo} <= 64-bit product, signed for MULT, unsigned for MULTU.
  - Stays IDLE; Done=1 next cycle.
- IDLE + Start + MADD / MSUB:
  - {Hi,Lo} <= {Hi,Lo} + or − signed(A)*signed(B).
  - Modulo 2^64; no overflow flag.
- IDLE + Start + MTHI / MTLO:
  - Hi<=A or Lo<=A; the other register is unchanged.
  - Done=1 next cycle.
- IDLE + Start + DIV/DIVU with B=0:
  - Hi and Lo unchanged; stays IDLE.
  - Done=1 and DivByZero=1 next cycle.
- IDLE + Start + DIV/DIVU with B≠0: capture operands, then go to DIV_RUN with the iteration counter at 0.
  - DIVU uses the raw operands.
  - DIV captures |A| and |B|, plus the quotient sign (A[31]^B[31]) and remainder sign (A[31]).
- DIV_RUN: one restoring-division step per cycle.
  - Shift the {rem,quo} 64-bit register left by 1.
  - Trial-subtract the divisor from rem; if the result is non-negative, keep it and set quo[0].
  - After counter=31 is processed, go to DIV_FIX.
- DIV_FIX:
  - Apply signs for DIV: quotient truncates toward zero; remainder takes the dividend's sign.
  - Write Lo<=quotient and Hi<=remainder, pulse Done, return to IDLE.
- Special case: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0. This falls out of the 32-bit magnitude wrap and must not trap.
- Start while Busy=1 is ignored; A, B and Op may change freely during DIV_RUN.
- Hi and Lo hold their old values throughout a divide until the DIV_FIX edge.

## Timing
- Reset (async, immediate): state=IDLE, Hi=Lo=0, Busy=Done=DivByZero=0, counter=0.
  - Reset mid-divide aborts the divide with no write.
- Non-divide ops and divide-by-zero, Start sampled at edge k:
  - Registers update at edge k.
  - Done is high for the cycle [k, k+1).
  - Busy never rises.
- Divide, Start sampled at edge k:
  - Busy is high from edge k to edge k+33.
  - 32 iteration edges: k+1 … k+32.
  - DIV_FIX write happens at edge k+33; Done is high for [k+33, k+34); Busy is low from k+33.
- A new Start is accepted at edge k+33 at the earliest.
- Done, Busy and DivByZero are registered outputs, not combinational from Start.

## Structure
- Shared package hilo_pkg holds:
  - the Op encodings (OP_MULT … OP_MTLO);
  - the state enum (S_IDLE, S_DIV_RUN, S_DIV_FIX);
  - DIV_STEPS = 32.
- One sub-module, div_step: combinational single restoring-division step.
  - Inputs: {rem,quo} and divisor. Output: next {rem,quo}.
  - Instantiated once; the top-level FSM registers its output each cycle.
- The multiplier and accumulator adder are inline in the top level.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3 → next cycle Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, Done=1.
- MULTU with the same operands → Hi=0x00000002, Lo=0xFFFFFFFA.
- MTHI A=0x1 and MTLO A=0xFFFFFFFF, then MADD A=1, B=1 → Hi=0x2, Lo=0x0.
  - Then MSUB A=1, B=1 → Hi=0x1, Lo=0xFFFFFFFF.
- DIV A=−7 (0xFFFFFFF9), B=2 → Busy high exactly 33 cycles, then Lo=0xFFFFFFFD, Hi=0xFFFFFFFF, Done pulse.
  - A Start with MTLO issued mid-divide has no effect.
- DIVU B=0 with Hi=0x5, Lo=0x6 → Hi and Lo unchanged; Done=DivByZero=1 for one cycle; Busy stays 0.
- DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
  - Separately, assert Rst at iteration 10 of a divide → Hi=Lo=0 and Busy=0 immediately; no Done pulse.
